// File: rtl/countdown_time_setter_if.sv
// Commit/display bus between the time setter and the countdown/display logic.
// The setter drives every signal; consumers watch load and time_data.
interface countdown_time_setter_if;
   logic [5:0]  set_min;
   logic [5:0]  set_sec;
   logic        load;
   logic        editing;
   logic [31:0] time_data;

   modport master (
      output set_min,
      output set_sec,
      output load,
      output editing,
      output time_data
   );

   modport slave (
      input set_min,
      input set_sec,
      input load,
      input editing,
      input time_data
   );
endinterface

// File: rtl/countdown_time_setter.sv
// Button-driven minutes:seconds editor for the countdown timers.
// Debounces four buttons, auto-repeats up/down, edits a working copy of the
// time and commits it with a one-cycle load strobe. Also drives the packed
// BCD display word, blanking the field under edit on the blink off phase.
module countdown_time_setter #(
   parameter int DEBOUNCE_CYC      = 2_000_000,
   parameter int REPEAT_DELAY_CYC  = 50_000_000,
   parameter int REPEAT_PERIOD_CYC = 10_000_000,
   parameter int BLINK_CYC         = 50_000_000,
   parameter int DEF_MIN           = 3,
   parameter int DEF_SEC           = 0,
   parameter int MAX_MIN           = 59
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     btn_up,
   input  logic                     btn_down,
   input  logic                     btn_sel,
   input  logic                     btn_ok,
   countdown_time_setter_if.master  setBus
);

   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   localparam int RW = $clog2(REPEAT_DELAY_CYC + 1);
   localparam int BW = $clog2(BLINK_CYC + 1);

   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYC - 1);
   localparam logic [RW-1:0] REP_FIRE   = RW'(REPEAT_DELAY_CYC);
   // After a repeat fires, the counter restarts so the next fire lands one
   // repeat period later.
   localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY_CYC - REPEAT_PERIOD_CYC + 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

   localparam logic [5:0] MIN_TOP = 6'(MAX_MIN);
   localparam logic [5:0] SEC_TOP = 6'd59;
   localparam logic [5:0] DEF_M   = 6'(DEF_MIN);
   localparam logic [5:0] DEF_S   = 6'(DEF_SEC);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EDIT_MIN = 2'd1,
      EDIT_SEC = 2'd2,
      COMMIT   = 2'd3
   } state_t;

   // Bit order of the button vectors: 0 up, 1 down, 2 sel, 3 ok.
   logic [3:0]    w_raw;
   logic [3:0]    r_level;
   logic [3:0]    r_levelD;
   logic [DW-1:0] r_debCnt [4];
   logic [3:0]    w_press;

   logic [RW-1:0] r_repCntUp;
   logic [RW-1:0] r_repCntDown;
   logic          w_repUp;
   logic          w_repDown;
   logic          w_bothHeld;
   logic          w_upEv;
   logic          w_downEv;
   logic          w_selEv;
   logic          w_okEv;

   state_t        r_state;
   state_t        w_nextState;
   logic [5:0]    r_workMin;
   logic [5:0]    r_workSec;
   logic [5:0]    w_nextWorkMin;
   logic [5:0]    w_nextWorkSec;
   logic [5:0]    r_setMin;
   logic [5:0]    r_setSec;
   logic          r_load;
   logic          w_commit;
   logic          w_blinkRestart;

   logic [BW-1:0] r_blinkCnt;
   logic          r_blinkOn;

   logic          w_editing;
   logic [31:0]   w_timeNext;
   logic [31:0]   r_timeData;

   function automatic logic [31:0] packTime(input logic [5:0] m, input logic [5:0] s);
      packTime = {8'h00, 4'hF, 4'(m / 6'd10), 4'(m % 6'd10),
                  4'hF, 4'(s / 6'd10), 4'(s % 6'd10)};
   endfunction

   assign w_raw = {btn_ok, btn_sel, btn_down, btn_up};

   // Debounce each button: the level flips only after the raw input has
   // disagreed with it for DEBOUNCE_CYC consecutive cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_level  <= '0;
         r_levelD <= '0;
         for (int i = 0; i < 4; i++) r_debCnt[i] <= '0;
      end else begin
         r_levelD <= r_level;
         for (int i = 0; i < 4; i++) begin
            if (w_raw[i] == r_level[i]) begin
               r_debCnt[i] <= '0;
            end else if (r_debCnt[i] == DEB_LAST) begin
               r_level[i]  <= w_raw[i];
               r_debCnt[i] <= '0;
            end else begin
               r_debCnt[i] <= r_debCnt[i] + 1'b1;
            end
         end
      end
   end

   assign w_press = r_level & ~r_levelD;

   // Hold counters for up/down auto-repeat; releasing the button clears them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_repCntUp   <= '0;
         r_repCntDown <= '0;
      end else begin
         if (!r_level[0])                r_repCntUp <= '0;
         else if (r_repCntUp == REP_FIRE) r_repCntUp <= REP_RELOAD;
         else                            r_repCntUp <= r_repCntUp + 1'b1;

         if (!r_level[1])                  r_repCntDown <= '0;
         else if (r_repCntDown == REP_FIRE) r_repCntDown <= REP_RELOAD;
         else                              r_repCntDown <= r_repCntDown + 1'b1;
      end
   end

   assign w_repUp    = r_level[0] && (r_repCntUp == REP_FIRE);
   assign w_repDown  = r_level[1] && (r_repCntDown == REP_FIRE);
   // Holding up and down together is ambiguous, so neither one steps.
   assign w_bothHeld = r_level[0] & r_level[1];
   assign w_upEv     = (w_press[0] | w_repUp)   & ~w_bothHeld;
   assign w_downEv   = (w_press[1] | w_repDown) & ~w_bothHeld;
   assign w_selEv    = w_press[2];
   assign w_okEv     = w_press[3];

   // Next state and working values; abort beats ok, ok beats sel, sel beats steps.
   always_comb begin
      w_nextState    = r_state;
      w_nextWorkMin  = r_workMin;
      w_nextWorkSec  = r_workSec;
      w_commit       = 1'b0;
      w_blinkRestart = 1'b0;
      case (r_state)
         IDLE: begin
            if (enable) begin
               w_nextState   = EDIT_MIN;
               w_nextWorkMin = r_setMin;
               w_nextWorkSec = r_setSec;
            end
         end
         EDIT_MIN: begin
            if (!enable) begin
               w_nextState = IDLE;
            end else if (w_okEv) begin
               w_nextState = COMMIT;
               w_commit    = 1'b1;
            end else if (w_selEv) begin
               w_nextState    = EDIT_SEC;
               w_blinkRestart = 1'b1;
            end else if (w_upEv) begin
               w_nextWorkMin  = (r_workMin >= MIN_TOP) ? 6'd0 : r_workMin + 6'd1;
               w_blinkRestart = 1'b1;
            end else if (w_downEv) begin
               w_nextWorkMin  = (r_workMin == 6'd0) ? MIN_TOP : r_workMin - 6'd1;
               w_blinkRestart = 1'b1;
            end
         end
         EDIT_SEC: begin
            if (!enable) begin
               w_nextState = IDLE;
            end else if (w_okEv) begin
               w_nextState = COMMIT;
               w_commit    = 1'b1;
            end else if (w_selEv) begin
               w_nextState    = EDIT_MIN;
               w_blinkRestart = 1'b1;
            end else if (w_upEv) begin
               w_nextWorkSec  = (r_workSec >= SEC_TOP) ? 6'd0 : r_workSec + 6'd1;
               w_blinkRestart = 1'b1;
            end else if (w_downEv) begin
               w_nextWorkSec  = (r_workSec == 6'd0) ? SEC_TOP : r_workSec - 6'd1;
               w_blinkRestart = 1'b1;
            end
         end
         COMMIT: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // State, working copy and committed value; load rises with the new value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_workMin <= DEF_M;
         r_workSec <= DEF_S;
         r_setMin  <= DEF_M;
         r_setSec  <= DEF_S;
         r_load    <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_workMin <= w_nextWorkMin;
         r_workSec <= w_nextWorkSec;
         r_load    <= w_commit;
         if (w_commit) begin
            r_setMin <= r_workMin;
            r_setSec <= r_workSec;
         end
      end
   end

   // Free-running blink phase, forced back on by any edit so changes show at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_blinkCnt <= '0;
         r_blinkOn  <= 1'b1;
      end else if (w_blinkRestart) begin
         r_blinkCnt <= '0;
         r_blinkOn  <= 1'b1;
      end else if (r_blinkCnt == BLINK_LAST) begin
         r_blinkCnt <= '0;
         r_blinkOn  <= ~r_blinkOn;
      end else begin
         r_blinkCnt <= r_blinkCnt + 1'b1;
      end
   end

   assign w_editing = (r_state == EDIT_MIN) || (r_state == EDIT_SEC);

   // Display word: working value while editing, committed value otherwise,
   // with the selected field replaced by the blank code during the off phase.
   always_comb begin
      w_timeNext = w_editing ? packTime(r_workMin, r_workSec)
                             : packTime(r_setMin, r_setSec);
      if (w_editing && !r_blinkOn) begin
         if (r_state == EDIT_MIN) w_timeNext[19:12] = 8'hEE;
         else                     w_timeNext[7:0]   = 8'hEE;
      end
   end

   // Register the display word so it trails working-register changes by one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_timeData <= packTime(DEF_M, DEF_S);
      else      r_timeData <= w_timeNext;
   end

   assign setBus.set_min   = r_setMin;
   assign setBus.set_sec   = r_setSec;
   assign setBus.load      = r_load;
   assign setBus.editing   = w_editing;
   assign setBus.time_data = r_timeData;

endmodule

// File: tb/tb_countdown_time_setter.sv
// Directed bench for countdown_time_setter with shortened timing parameters.
module tb_countdown_time_setter;

   logic clk;
   logic rst;
   logic enable;
   logic btnUp;
   logic btnDown;
   logic btnSel;
   logic btnOk;

   int          vecCount;
   int          errCount;
   int          loadCount;
   logic [5:0]  lastMin;
   logic [5:0]  lastSec;

   countdown_time_setter_if cif ();

   countdown_time_setter #(
      .DEBOUNCE_CYC      (4),
      .REPEAT_DELAY_CYC  (20),
      .REPEAT_PERIOD_CYC (5),
      .BLINK_CYC         (16),
      .DEF_MIN           (3),
      .DEF_SEC           (0),
      .MAX_MIN           (59)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .btn_up   (btnUp),
      .btn_down (btnDown),
      .btn_sel  (btnSel),
      .btn_ok   (btnOk),
      .setBus   (cif.master)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count load cycles and capture the committed value seen alongside each one
   always @(negedge clk) begin
      if (cif.load === 1'b1) begin
         loadCount = loadCount + 1;
         lastMin   = cif.set_min;
         lastSec   = cif.set_sec;
      end
   end

   // Hold the buttons in mask (0 up, 1 down, 2 sel, 3 ok) for hold cycles,
   // then release and let the debounced levels settle
   task automatic applyStimulus(input logic [3:0] mask, input int hold);
      btnUp   = mask[0];
      btnDown = mask[1];
      btnSel  = mask[2];
      btnOk   = mask[3];
      repeat (hold) @(negedge clk);
      btnUp   = 1'b0;
      btnDown = 1'b0;
      btnSel  = 1'b0;
      btnOk   = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecCount = vecCount + 1;
      assert (obs === exp)
      else begin
         errCount = errCount + 1;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      vecCount  = 0;
      errCount  = 0;
      loadCount = 0;
      lastMin   = '0;
      lastSec   = '0;
      rst       = 1'b0;
      enable    = 1'b0;
      btnUp     = 1'b0;
      btnDown   = 1'b0;
      btnSel    = 1'b0;
      btnOk     = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Reset state
      checkOutput("reset_time_data", cif.time_data, 32'h00F03F00);
      checkOutput("reset_set_min", 32'(cif.set_min), 32'd3);
      checkOutput("reset_set_sec", 32'(cif.set_sec), 32'd0);
      checkOutput("reset_load", 32'(cif.load), 32'd0);
      checkOutput("reset_editing", 32'(cif.editing), 32'd0);

      // Enter edit mode, then a 2-cycle glitch that must be filtered
      enable = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("enter_editing", 32'(cif.editing), 32'd1);
      applyStimulus(4'b0001, 2);
      repeat (4) @(negedge clk);

      // Auto-repeat: press plus five repeats takes minutes 3 -> 9
      applyStimulus(4'b0001, 43);
      checkOutput("repeat_min9", cif.time_data, 32'h00F09F00);

      // Abort: edit to 7, drop enable, committed value must survive
      applyStimulus(4'b0010, 6);
      applyStimulus(4'b0010, 6);
      checkOutput("abort_edit_min7", cif.time_data, 32'h00F07F00);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("abort_editing", 32'(cif.editing), 32'd0);
      checkOutput("abort_no_load", 32'(loadCount), 32'd0);
      checkOutput("abort_set_min", 32'(cif.set_min), 32'd3);
      checkOutput("abort_idle_time", cif.time_data, 32'h00F03F00);
      enable = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reenter_editing", 32'(cif.editing), 32'd1);
      applyStimulus(4'b0100, 6);
      checkOutput("reenter_work_min3", cif.time_data, 32'h00F03F00);
      applyStimulus(4'b0100, 6);
      checkOutput("back_to_min", cif.time_data, 32'h00F03F00);

      // Basic edit: up, up, sel, down, ok -> 05:59 committed
      applyStimulus(4'b0001, 6);
      checkOutput("edit_min4", cif.time_data, 32'h00F04F00);
      applyStimulus(4'b0001, 6);
      checkOutput("edit_min5", cif.time_data, 32'h00F05F00);
      applyStimulus(4'b0100, 6);
      checkOutput("edit_sel_sec", cif.time_data, 32'h00F05F00);
      applyStimulus(4'b0010, 6);
      checkOutput("sec_wrap_0_to_59", cif.time_data, 32'h00F05F59);
      applyStimulus(4'b1000, 6);
      checkOutput("commit_load_once", 32'(loadCount), 32'd1);
      checkOutput("commit_set_min", 32'(lastMin), 32'd5);
      checkOutput("commit_set_sec", 32'(lastSec), 32'd59);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("idle_committed_time", cif.time_data, 32'h00F05F59);
      checkOutput("idle_set_min", 32'(cif.set_min), 32'd5);

      // Wrap: six downs from 5 reach 59, then up wraps to 0
      enable = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 6; i++) applyStimulus(4'b0010, 6);
      checkOutput("min_wrap_0_to_59", cif.time_data, 32'h00F59F59);
      applyStimulus(4'b0001, 6);
      checkOutput("min_wrap_59_to_0", cif.time_data, 32'h00F00F59);
      applyStimulus(4'b0100, 6);
      applyStimulus(4'b0001, 6);
      checkOutput("sec_wrap_59_to_0", cif.time_data, 32'h00F00F00);
      applyStimulus(4'b0010, 6);
      checkOutput("sec_back_to_59", cif.time_data, 32'h00F00F59);

      // Priority: ok and up together commits without stepping
      applyStimulus(4'b1001, 6);
      checkOutput("prio_load", 32'(loadCount), 32'd2);
      checkOutput("prio_set_min", 32'(lastMin), 32'd0);
      checkOutput("prio_set_sec", 32'(lastSec), 32'd59);

      // Blink: select seconds, wait into the off phase, then back on
      applyStimulus(4'b0100, 6);
      repeat (10) @(negedge clk);
      checkOutput("blink_off_sec", cif.time_data, 32'h00F00FEE);
      repeat (16) @(negedge clk);
      checkOutput("blink_on_sec", cif.time_data, 32'h00F00F59);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule

// File: doc/countdown_time_setter.md
Name: countdown_time_setter

Overview:
- User-facing writer for the countdown timers: edits a minutes:seconds value with four push-buttons and commits it to the consuming countdown block through a one-cycle load strobe.
- Emits the same packed 32-bit time_data display format the countdown blocks feed to the digit display, with the field under edit blinking.
- Sits between the board buttons and the mode/countdown logic; active only while `enable` is high.

Parameters:
- DEBOUNCE_CYC, 2_000_000: cycles a raw button must be stable before its debounced level changes (20 ms at 100 MHz).
- REPEAT_DELAY_CYC, 50_000_000: hold time before auto-repeat starts on up/down.
- REPEAT_PERIOD_CYC, 10_000_000: auto-repeat step interval.
- BLINK_CYC, 50_000_000: half-period of the selected-field blink.
- DEF_MIN, 3: reset minutes value.
- DEF_SEC, 0: reset seconds value.
- MAX_MIN, 59: upper bound on minutes.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  setting mode active; low aborts editing.
- btn_up  input  1  raw increment button, active-high.
- btn_down  input  1  raw decrement button, active-high.
- btn_sel  input  1  raw field-select button, active-high.
- btn_ok  input  1  raw confirm button, active-high.
- set_min  output  6  committed minutes.
- set_sec  output  6  committed seconds.
- load  output  1  one-cycle strobe when a new value is committed.
- editing  output  1  high in EDIT_MIN or EDIT_SEC.
- time_data  output  32  packed BCD display word.

Behaviour:
- Reset values while rst is low (asynchronous): set_min=DEF_MIN, set_sec=DEF_SEC, working regs=DEF, state IDLE, load=0, editing=0, all debounce/repeat/blink counters 0, debounced levels 0.
- Debounce, per button: counter clears whenever raw equals the debounced level. Debounced level flips after DEBOUNCE_CYC consecutive differing cycles. Press event = one-cycle pulse on the debounced rising edge.
- Auto-repeat (up/down only): while the debounced level is held, an extra step event fires at REPEAT_DELAY_CYC after the press, then every REPEAT_PERIOD_CYC. Release clears the repeat counter.
- up and down both debounced-high: neither press nor repeat events take effect.
- FSM states: IDLE, EDIT_MIN, EDIT_SEC, COMMIT.
- IDLE: when enable is high, go to EDIT_MIN and copy the committed values into the working regs.
- EDIT_MIN: sel event -> EDIT_SEC. up -> min+1, wraps MAX_MIN to 0. down -> min-1, wraps 0 to MAX_MIN.
- EDIT_SEC: sel event -> EDIT_MIN. up/down step seconds, wrapping 59<->0.
- ok event in EDIT_MIN or EDIT_SEC -> COMMIT.
- COMMIT (one cycle): set_min/set_sec take the working values, load=1, then go to IDLE. Re-entry to EDIT_MIN follows on the next cycle if enable is still high.
- Abort: enable low in any EDIT state -> IDLE the next cycle. Working values are discarded and no load strobe is issued.
- Same-cycle events: ok has priority over sel and up/down. sel has priority over up/down.
- Output timing: load is registered, exactly one cycle wide, and coincident with the updated set_min/set_sec.
- time_data layout:
  - [31:24] = 8'h00.
  - [23:20] = 4'hF and [11:8] = 4'hF (separators).
  - [19:16] = min/10, [15:12] = min%10.
  - [7:4] = sec/10, [3:0] = sec%10.
- time_data source: working values while editing, committed values in IDLE.
- Blink: a free-running blink phase toggles every BLINK_CYC. During the off phase, the selected field's two nibbles read 4'hE (blank code).
- Blink restart: a step or sel event restarts the blink counter with the phase forced on, so an edited value is shown immediately.
- time_data is registered, with 1-cycle latency from a working-register change.

Test Plan:
(Simulation parameters: DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=20, REPEAT_PERIOD_CYC=5, BLINK_CYC=16.)
- Reset: after release, time_data=32'h00F03F00, set_min=3, set_sec=0, load=0. A 2-cycle glitch on btn_up changes nothing.
- Basic edit: enable=1, press up twice, sel, down once, ok. Result: load high for exactly 1 cycle with set_min=5, set_sec=59, time_data=32'h00F05F59 in IDLE.
- Wrap: at min=59 an up press gives 0. At sec=0 a down press gives 59.
- Auto-repeat: hold up for 40 cycles after debounce in EDIT_MIN. Expect 1 press step + 5 repeat steps, min 3->9.
- Abort: edit min to 7, drop enable. No load; set_min stays 3. Re-enable: working min reads 3.
- Priority/blink: ok and up debounced in the same cycle -> commit without the increment. In EDIT_SEC off phase, time_data[7:0]=8'hEE while minute nibbles are unchanged.
